// File: rtl/turbo_stream_checker.sv
// Receive-side checker: re-encodes recovered systematic bits with constituent
// encoder 1 and compares the parity and trellis termination against the stream.
module turbo_stream_checker #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cb_size_in,
  input  logic             wreq_size,
  input  logic             in_valid,
  input  logic             xk_in,
  input  logic             zk_in,
  input  logic             zk_prime_in,
  output logic             data_out,
  output logic             data_valid,
  output logic             zp_out,
  output logic [CNT_W-1:0] parity_err_cnt,
  output logic             tail_err,
  output logic             block_done,
  output logic [2:0]       d_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DATA  = 3'd2,
    ST_TAIL1 = 3'd3,
    ST_TAIL2 = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] K_SMALL = CNT_W'(1056);
  localparam logic [CNT_W-1:0] K_LARGE = CNT_W'(6144);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             zp_out_q, zp_out_d;
  logic [CNT_W-1:0] perr_q, perr_d;
  logic             terr_q, terr_d;
  logic             done_q, done_d;

  logic             fb_s;
  logic             exp_z_s;
  logic             tail_x_s;
  logic             tail_z_s;
  logic [CNT_W-1:0] perr_inc_s;

  // RSC data step (feedback 1+D^2+D^3, parity 1+D+D^3) and tail step
  assign fb_s       = xk_in ^ s2_q ^ s3_q;
  assign exp_z_s    = fb_s ^ s1_q ^ s3_q;
  assign tail_x_s   = s2_q ^ s3_q;
  assign tail_z_s   = s1_q ^ s3_q;
  assign perr_inc_s = (perr_q == CNT_MAX) ? perr_q : perr_q + CNT_W'(1);

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    s3_d         = s3_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    zp_out_d     = zp_out_q;
    perr_d       = perr_q;
    terr_d       = terr_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wreq_size && ((cb_size_in == K_SMALL) || (cb_size_in == K_LARGE))) begin
          k_d     = cb_size_in;
          state_d = ST_WAIT;
          s1_d    = 1'b0;
          s2_d    = 1'b0;
          s3_d    = 1'b0;
          cnt_d   = CNT_W'(0);
          perr_d  = CNT_W'(0);
          terr_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT, ST_DATA: begin
        if (in_valid) begin
          s1_d         = fb_s;
          s2_d         = s1_q;
          s3_d         = s2_q;
          data_out_d   = xk_in;
          data_valid_d = 1'b1;
          zp_out_d     = zk_prime_in;
          cnt_d        = cnt_q + CNT_W'(1);
          if (zk_in != exp_z_s) begin
            perr_d = perr_inc_s;
          end else begin
            perr_d = perr_q;
          end
          // the counter keeps running through the tail so no dead cycle is needed
          if (cnt_q == k_q - CNT_W'(1)) begin
            state_d = ST_TAIL1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_TAIL1: begin
        if (in_valid) begin
          s1_d     = 1'b0;
          s2_d     = s1_q;
          s3_d     = s2_q;
          zp_out_d = zk_prime_in;
          cnt_d    = cnt_q + CNT_W'(1);
          if ((xk_in != tail_x_s) || (zk_in != tail_z_s)) begin
            terr_d = 1'b1;
          end else begin
            terr_d = terr_q;
          end
          if (cnt_q == k_q + CNT_W'(2)) begin
            state_d = ST_TAIL2;
          end else begin
            state_d = ST_TAIL1;
          end
        end else begin
          state_d = ST_TAIL1;
        end
      end
      ST_TAIL2: begin
        if (in_valid) begin
          zp_out_d = zk_prime_in;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == k_q + CNT_W'(5)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_TAIL2;
          end
        end else begin
          state_d = ST_TAIL2;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= CNT_W'(0);
      k_q          <= CNT_W'(0);
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      zp_out_q     <= 1'b0;
      perr_q       <= CNT_W'(0);
      terr_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      zp_out_q     <= zp_out_d;
      perr_q       <= perr_d;
      terr_q       <= terr_d;
      done_q       <= done_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign zp_out         = zp_out_q;
  assign parity_err_cnt = perr_q;
  assign tail_err       = terr_q;
  assign block_done     = done_q;
  assign d_state        = state_q;

endmodule
